pixel_collector: RTL and testbench
==================================

// Module: pixel_collector
// PURPOSE
//   Downstream of the NUM_SOLVERS pattern_solver instances. Round-robin arbitrates among
//   solvers with a result ready. Writes each 4-bit iteration colour to the framebuffer at
//   row*NUM_COLUMNS+column, then pulses that solver's continue to start its next pixel.
//   Tracks each solver's raster position, since solvers do not export it. Flags frame_done.
// PARAMETERS
//   NUM_SOLVERS  1    solver count; solver i owns rows i, i+N, i+2N, ...
//   NUM_COLUMNS  640  pixels per row
//   NUM_ROWS     480  rows per frame
//   ADDR_W       19   framebuffer address width; must hold NUM_COLUMNS*NUM_ROWS-1
// PORTS
//   clock        in   1              clock
//   reset        in   1              synchronous, active-high
//   solver_ready in   NUM_SOLVERS    bit i: solver i result valid
//   solver_out   in   4*NUM_SOLVERS  [4i+3:4i]: solver i colour
//   solver_done  in   NUM_SOLVERS    bit i: solver i finished its rows
//   continue     out  NUM_SOLVERS    one-cycle pulse: release solver i to next pixel
//   wr_valid     out  1              framebuffer write request
//   wr_ready     in   1              framebuffer accepts when wr_valid&&wr_ready
//   wr_addr      out  ADDR_W         write address
//   wr_data      out  4              write colour
//   pixel_count  out  ADDR_W+1       pixels written since reset
//   frame_done   out  1              all pixels written; sticky until reset
// BEHAVIOUR
//   Reset values: continue=0, wr_valid=0, wr_addr=0, wr_data=0, pixel_count=0, frame_done=0.
//   Reset clears state to SCAN and rr_ptr to 0. It sets col[i]=0, row[i]=i and addr[i]=i*NUM_COLUMNS.
//   Reset is honoured in any state and abandons an in-flight write; no continue pulse is issued.
//   Eligible(i) = solver_ready[i] & ~solver_done[i] & (row[i]<NUM_ROWS) & ~holdoff[i].
//   Solvers with row[i]>=NUM_ROWS at reset are never eligible.
//   FSM, all outputs registered:
//   SCAN: the first eligible i at or after rr_ptr (wrapping) is granted.
//     On grant: sel<=i, wr_data<=solver_out[i], wr_addr<=addr[i], wr_valid<=1, go WRITE.
//     If none is eligible, stay in SCAN.
//   WRITE: hold wr_valid/wr_addr/wr_data stable until wr_valid&&wr_ready (wr_ready may stall).
//     On accept: wr_valid<=0, continue[sel]<=1 for exactly one cycle.
//     Also on accept: pixel_count+=1, rr_ptr<=(sel+1)%NUM_SOLVERS, advance sel's position, go HOLD.
//   HOLD: one cycle with continue=0. Then go to SCAN, or to DONE if pixel_count==NUM_COLUMNS*NUM_ROWS.
//   DONE: frame_done=1; no grants or continue pulses until reset.
//   Position advance for solver s:
//     If col[s]==NUM_COLUMNS-1: col<=0, row<=row+NUM_SOLVERS,
//       addr<=addr+1+(NUM_SOLVERS-1)*NUM_COLUMNS.
//     Else: col<=col+1, addr<=addr+1.
//     Address is incremental; no multiplier.
//   holdoff[s] is set at its continue pulse and cleared 2 cycles later.
//     This masks a stale ready while the solver restarts.
//   Minimum 3 cycles per pixel with wr_ready held 1: SCAN->WRITE->HOLD.
//   Simultaneous readies: only one grant per SCAN; losers keep ready asserted and wait.
//     The round-robin pointer guarantees each waits at most NUM_SOLVERS-1 grants.
//   solver_ready deasserting while in WRITE does not cancel the write; data is already latched.
//   Widths: addr arithmetic is done in ADDR_W+1 bits and truncated; pixel_count saturates at the frame size.
// TESTING
//   N=1, 4x3 frame, solver model ready every 5 cycles, colours 0..11, wr_ready=1
//     -> 12 writes with addr 0..11 in order; frame_done high 1 cycle after HOLD of 12th.
//   N=2, 4x3, both ready same cycle
//     -> writes at addr 0 (solver 0), then 4 (solver 1), then 1, 5...;
//        solver 1 rows 1 only, solver 0 rows 0,2.
//   wr_ready low 7 cycles during WRITE
//     -> wr_addr/wr_data stable throughout; no continue until accept; exactly one continue pulse.
//   Ready held high continuously by solver 0 (N=1)
//     -> one write per pixel, no duplicate at same address, continue spacing >=3 cycles.
//   N=4, NUM_ROWS=3: solver 3 asserts ready
//     -> ignored; 3*NUM_COLUMNS writes then frame_done.
//   Reset asserted in WRITE with wr_ready=0
//     -> next cycle wr_valid=0, pixel_count=0, no continue; restart writes addr 0.

Source files
------------

// File: rtl/pixel_collector.sv
// pixel_collector
//   Collects colour results from NUM_SOLVERS pattern solvers and writes them to the
//   framebuffer. Solver i owns rows i, i+N, i+2N, ... The collector tracks each solver's
//   raster position because solvers do not report it. Ready solvers are served round-robin.
//   After each accepted write the owning solver gets a one-cycle continue pulse.
//   frame_done rises once every pixel of the frame has been written.
//
//   state | meaning
//   SCAN  | looking for an eligible solver, starting at rr_q
//   WRITE | write request held on the bus until wr_ready_i accepts it
//   HOLD  | one idle cycle after an accept (continue pulse is visible here)
//   DONE  | frame complete, frame_done_o high, no further grants until reset
//
// Ports
//   clock, reset        clock; synchronous active-high reset
//   solver_ready_i[i]   solver i has a result
//   solver_out_i        solver i colour on bits [4i+3:4i]
//   solver_done_i[i]    solver i has finished all of its rows
//   continue_o[i]       one-cycle pulse that releases solver i to its next pixel
//   wr_valid_o/ready_i  framebuffer write handshake
//   wr_addr_o/data_o    framebuffer write address and colour
//   pixel_count_o       pixels written since reset, saturating at the frame size
//   frame_done_o        sticky frame-complete flag
module pixel_collector #(
   parameter int NUM_SOLVERS = 1,
   parameter int NUM_COLUMNS = 640,
   parameter int NUM_ROWS    = 480,
   parameter int ADDR_W      = 19
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_SOLVERS-1:0]   solver_ready_i,
   input  logic [4*NUM_SOLVERS-1:0] solver_out_i,
   input  logic [NUM_SOLVERS-1:0]   solver_done_i,
   output logic [NUM_SOLVERS-1:0]   continue_o,
   output logic                     wr_valid_o,
   input  logic                     wr_ready_i,
   output logic [ADDR_W-1:0]        wr_addr_o,
   output logic [3:0]               wr_data_o,
   output logic [ADDR_W:0]          pixel_count_o,
   output logic                     frame_done_o
);

   localparam int SEL_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
   localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
   // Rows can step one stride past the last row before the solver goes ineligible.
   localparam int ROW_W = $clog2(NUM_ROWS + NUM_SOLVERS);

   localparam logic [ADDR_W:0]  FRAME_PIX = (ADDR_W+1)'(NUM_COLUMNS * NUM_ROWS);
   // Jump from the end of one owned row to the start of the next owned row.
   localparam logic [ADDR_W:0]  ROW_STEP  = (ADDR_W+1)'((NUM_SOLVERS - 1) * NUM_COLUMNS + 1);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLUMNS - 1);
   localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(NUM_ROWS);
   localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_SOLVERS - 1);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_WRITE,
      ST_HOLD,
      ST_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [SEL_W-1:0]       rr_q, rr_d;
   logic                   wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
   logic [3:0]             wr_data_q, wr_data_d;
   logic [NUM_SOLVERS-1:0] cont_q, cont_d;
   logic [ADDR_W:0]        pix_q, pix_d;
   logic                   done_q, done_d;

   logic [COL_W-1:0]       col_q  [NUM_SOLVERS];
   logic [COL_W-1:0]       col_d  [NUM_SOLVERS];
   logic [ROW_W-1:0]       row_q  [NUM_SOLVERS];
   logic [ROW_W-1:0]       row_d  [NUM_SOLVERS];
   logic [ADDR_W-1:0]      addr_q [NUM_SOLVERS];
   logic [ADDR_W-1:0]      addr_d [NUM_SOLVERS];
   // Down-counter masking a stale ready for two cycles after continue.
   logic [1:0]             hold_q [NUM_SOLVERS];
   logic [1:0]             hold_d [NUM_SOLVERS];

   logic [NUM_SOLVERS-1:0] eligible;
   logic                   grant_found;
   logic                   hi_found;
   logic [SEL_W-1:0]       hi_idx, low_idx, grant_idx;
   logic [3:0]             grant_colour;
   logic [ADDR_W-1:0]      grant_addr;
   logic [ADDR_W:0]        addr_sum;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_SOLVERS; i++) begin
         eligible[i] = solver_ready_i[i] & ~solver_done_i[i] &
                       (row_q[i] < ROW_LIMIT) & (hold_q[i] == 2'd0);
      end
   end

   // Round-robin: lowest eligible index at or above rr_q, else lowest eligible overall.
   // Descending loops leave the lowest matching index in the result.
   always_comb begin
      hi_found     = 1'b0;
      hi_idx       = '0;
      low_idx      = '0;
      grant_colour = '0;
      grant_addr   = '0;
      for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            low_idx = SEL_W'(i);
            if (SEL_W'(i) >= rr_q) begin
               hi_found = 1'b1;
               hi_idx   = SEL_W'(i);
            end
         end
      end
      grant_found = |eligible;
      grant_idx   = hi_found ? hi_idx : low_idx;
      for (int i = 0; i < NUM_SOLVERS; i++) begin
         if (SEL_W'(i) == grant_idx) begin
            grant_colour = solver_out_i[4*i +: 4];
            grant_addr   = addr_q[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rr_d       = rr_q;
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      cont_d     = '0;
      pix_d      = pix_q;
      done_d     = done_q;
      col_d      = col_q;
      row_d      = row_q;
      addr_d     = addr_q;
      addr_sum   = '0;
      for (int i = 0; i < NUM_SOLVERS; i++) begin
         hold_d[i] = (hold_q[i] != 2'd0) ? hold_q[i] - 2'd1 : 2'd0;
      end

      case (state_q)
         ST_SCAN: begin
            if (grant_found) begin
               sel_d      = grant_idx;
               wr_data_d  = grant_colour;
               wr_addr_d  = grant_addr;
               wr_valid_d = 1'b1;
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (wr_ready_i) begin
               wr_valid_d = 1'b0;
               if (pix_q != FRAME_PIX) begin
                  pix_d = pix_q + (ADDR_W+1)'(1);
               end
               rr_d = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
               for (int i = 0; i < NUM_SOLVERS; i++) begin
                  if (SEL_W'(i) == sel_q) begin
                     cont_d[i] = 1'b1;
                     hold_d[i] = 2'd2;
                     if (col_q[i] == LAST_COL) begin
                        col_d[i] = '0;
                        row_d[i] = row_q[i] + ROW_W'(NUM_SOLVERS);
                        addr_sum = {1'b0, addr_q[i]} + ROW_STEP;
                     end else begin
                        col_d[i] = col_q[i] + COL_W'(1);
                        addr_sum = {1'b0, addr_q[i]} + (ADDR_W+1)'(1);
                     end
                     addr_d[i] = addr_sum[ADDR_W-1:0];
                  end
               end
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (pix_q == FRAME_PIX) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_SCAN;
            end
         end
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            state_d = ST_SCAN;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_SCAN;
         sel_q      <= '0;
         rr_q       <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cont_q     <= '0;
         pix_q      <= '0;
         done_q     <= 1'b0;
         for (int i = 0; i < NUM_SOLVERS; i++) begin
            col_q[i]  <= '0;
            row_q[i]  <= ROW_W'(i);
            addr_q[i] <= ADDR_W'(i * NUM_COLUMNS);
            hold_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         rr_q       <= rr_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         cont_q     <= cont_d;
         pix_q      <= pix_d;
         done_q     <= done_d;
         col_q      <= col_d;
         row_q      <= row_d;
         addr_q     <= addr_d;
         hold_q     <= hold_d;
      end
   end

   assign continue_o    = cont_q;
   assign wr_valid_o    = wr_valid_q;
   assign wr_addr_o     = wr_addr_q;
   assign wr_data_o     = wr_data_q;
   assign pixel_count_o = pix_q;
   assign frame_done_o  = done_q;

endmodule

// File: tb/tb_pixel_collector.sv
// Bench for pixel_collector: 4 solvers, 4x3 frame, so solver 3 owns no valid row.
module tb_pixel_collector;

   localparam int N     = 4;
   localparam int C     = 4;
   localparam int R     = 3;
   localparam int AW    = 5;
   localparam int FRAME = C * R;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    solver_ready, solver_done, continue_o;
   logic [4*N-1:0]  solver_out;
   logic            wr_valid, wr_ready;
   logic [AW-1:0]   wr_addr;
   logic [3:0]      wr_data;
   logic [AW:0]     pixel_count;
   logic            frame_done;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   pixel_collector #(
      .NUM_SOLVERS(N), .NUM_COLUMNS(C), .NUM_ROWS(R), .ADDR_W(AW)
   ) dut (
      .clock(clock), .reset(reset),
      .solver_ready_i(solver_ready), .solver_out_i(solver_out), .solver_done_i(solver_done),
      .continue_o(continue_o), .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
      .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .pixel_count_o(pixel_count), .frame_done_o(frame_done)
   );

   typedef struct packed {
      logic [N-1:0]  ready;
      logic          wrr;
      logic          valid;
      logic [AW-1:0] addr;
      logic [3:0]    data;
      logic [N-1:0]  cont;
      logic [AW:0]   pc;
   } vec_t;

   vec_t tbl [17];

   // random-frame model state
   int         q [N][$];
   logic       rdy [N];
   int         dly [N];
   logic [3:0] colr [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      solver_ready = '0;
      solver_done = '0;
      wr_ready = 1'b0;
      solver_out = '0;
      tick();
      tick();
      chk("rst_valid", 32'(wr_valid), 0);
      chk("rst_addr", 32'(wr_addr), 0);
      chk("rst_data", 32'(wr_data), 0);
      chk("rst_cont", 32'(continue_o), 0);
      chk("rst_pc", 32'(pixel_count), 0);
      chk("rst_fd", 32'(frame_done), 0);
      reset = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int limit);
      int n;
      n = 0;
      while (!wr_valid && n < limit) begin
         tick();
         n++;
      end
      chk({name, "_timeout"}, 32'(wr_valid), 1);
   endtask

   task automatic drive_rand();
      for (int s = 0; s < N - 1; s++) begin
         solver_ready[s] = rdy[s];
         solver_done[s]  = (q[s].size() == 0);
         solver_out[4*s +: 4] = colr[s];
      end
      solver_ready[N-1] = 1'($urandom_range(0, 1));
      solver_done[N-1]  = 1'b0;
      solver_out[4*(N-1) +: 4] = 4'($urandom_range(0, 15));
      wr_ready = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // {ready, wr_ready, exp valid, exp addr, exp data, exp continue, exp pixel_count}
      tbl[0]  = '{4'hF, 1'b1, 1'b1, 5'd0, 4'hA, 4'h0, 6'd0};
      tbl[1]  = '{4'h0, 1'b0, 1'b1, 5'd0, 4'hA, 4'h0, 6'd0};
      tbl[2]  = '{4'hF, 1'b1, 1'b0, 5'd0, 4'hA, 4'h1, 6'd1};
      tbl[3]  = '{4'hF, 1'b1, 1'b0, 5'd0, 4'hA, 4'h0, 6'd1};
      tbl[4]  = '{4'hF, 1'b1, 1'b1, 5'd4, 4'h5, 4'h0, 6'd1};
      tbl[5]  = '{4'hF, 1'b1, 1'b0, 5'd4, 4'h5, 4'h2, 6'd2};
      tbl[6]  = '{4'hF, 1'b1, 1'b0, 5'd4, 4'h5, 4'h0, 6'd2};
      tbl[7]  = '{4'hF, 1'b1, 1'b1, 5'd8, 4'h3, 4'h0, 6'd2};
      tbl[8]  = '{4'hF, 1'b1, 1'b0, 5'd8, 4'h3, 4'h4, 6'd3};
      tbl[9]  = '{4'hF, 1'b1, 1'b0, 5'd8, 4'h3, 4'h0, 6'd3};
      tbl[10] = '{4'hF, 1'b1, 1'b1, 5'd1, 4'hA, 4'h0, 6'd3};
      tbl[11] = '{4'hF, 1'b1, 1'b0, 5'd1, 4'hA, 4'h1, 6'd4};
      tbl[12] = '{4'h1, 1'b1, 1'b0, 5'd1, 4'hA, 4'h0, 6'd4};
      tbl[13] = '{4'h1, 1'b1, 1'b0, 5'd1, 4'hA, 4'h0, 6'd4};
      tbl[14] = '{4'h1, 1'b1, 1'b1, 5'd2, 4'hA, 4'h0, 6'd4};
      tbl[15] = '{4'h1, 1'b1, 1'b0, 5'd2, 4'hA, 4'h1, 6'd5};
      tbl[16] = '{4'h0, 1'b1, 1'b0, 5'd2, 4'hA, 4'h0, 6'd5};

      // ---- table: simultaneous readies, round-robin, stall, holdoff
      reset_dut();
      solver_out = 16'hF35A;
      for (int k = 0; k < 17; k++) begin
         solver_ready = tbl[k].ready;
         wr_ready     = tbl[k].wrr;
         tick();
         chk($sformatf("tbl%0d_valid", k), 32'(wr_valid), 32'(tbl[k].valid));
         chk($sformatf("tbl%0d_addr", k), 32'(wr_addr), 32'(tbl[k].addr));
         chk($sformatf("tbl%0d_data", k), 32'(wr_data), 32'(tbl[k].data));
         chk($sformatf("tbl%0d_cont", k), 32'(continue_o), 32'(tbl[k].cont));
         chk($sformatf("tbl%0d_pc", k), 32'(pixel_count), 32'(tbl[k].pc));
      end

      // ---- wr_ready low 7 cycles, then reset in WRITE
      reset_dut();
      solver_out   = 16'hF35A;
      solver_ready = 4'b0010;
      wr_ready     = 1'b0;
      wait_valid("stall", 20);
      chk("stall_addr0", 32'(wr_addr), 4);
      chk("stall_data0", 32'(wr_data), 5);
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("stall_valid", 32'(wr_valid), 1);
         chk("stall_addr", 32'(wr_addr), 4);
         chk("stall_data", 32'(wr_data), 5);
         chk("stall_cont", 32'(continue_o), 0);
      end
      wr_ready = 1'b1;
      tick();
      chk("stall_accept_cont", 32'(continue_o), 32'h2);
      chk("stall_accept_valid", 32'(wr_valid), 0);
      chk("stall_accept_pc", 32'(pixel_count), 1);
      wr_ready = 1'b0;
      tick();
      chk("stall_single_pulse", 32'(continue_o), 0);
      wait_valid("second", 20);
      chk("second_addr", 32'(wr_addr), 5);
      reset = 1'b1;
      tick();
      chk("rstw_valid", 32'(wr_valid), 0);
      chk("rstw_pc", 32'(pixel_count), 0);
      chk("rstw_cont", 32'(continue_o), 0);
      reset        = 1'b0;
      solver_ready = 4'b0001;
      wr_ready     = 1'b1;
      wait_valid("restart", 20);
      chk("restart_addr", 32'(wr_addr), 0);
      chk("restart_data", 32'(wr_data), 32'hA);

      // ---- solver 0 ready held high continuously
      begin
         int nw, last_c, expa;
         logic pv;
         reset_dut();
         solver_out   = 16'hF35A;
         solver_ready = 4'b0001;
         wr_ready     = 1'b1;
         nw = 0; last_c = -100; expa = 0; pv = 1'b0;
         for (int c = 0; c < 40; c++) begin
            tick();
            if (wr_valid && !pv) begin
               chk("hold_addr", 32'(wr_addr), 32'(expa));
               expa++;
               nw++;
            end
            if (continue_o != '0) begin
               chk("hold_pulse", 32'(continue_o), 1);
               chk("hold_gap", 32'((c - last_c) >= 3), 1);
               last_c = c;
            end
            pv = wr_valid;
         end
         chk("hold_writes", 32'(nw), 4);
         chk("hold_pc", 32'(pixel_count), 4);
      end

      // ---- randomized frames against a queue-based model
      for (int f = 0; f < 3; f++) begin
         int rr, written, pending;
         logic pv, fd_wait, fin;
         logic [AW-1:0] paddr;
         logic [3:0] pdata;
         logic [N-1:0] a_ready, a_done;
         logic a_wrr;
         reset_dut();
         for (int s = 0; s < N; s++) begin
            q[s].delete();
            for (int r = s; r < R; r += N)
               for (int c = 0; c < C; c++) q[s].push_back(r * C + c);
            rdy[s]  = 1'b0;
            dly[s]  = $urandom_range(0, 4);
            colr[s] = 4'($urandom_range(0, 15));
         end
         rr = 0; written = 0; pending = -1;
         pv = 1'b0; fd_wait = 1'b0; fin = 1'b0; paddr = '0; pdata = '0;
         drive_rand();
         for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            a_ready = solver_ready;
            a_done  = solver_done;
            a_wrr   = wr_ready;
            tick();
            if (fd_wait) begin
               chk("rnd_frame_done", 32'(frame_done), 1);
               chk("rnd_final_pc", 32'(pixel_count), FRAME);
               fin = 1'b1;
            end
            if (wr_valid && !pv) begin
               int g;
               g = -1;
               for (int k = 0; k < N; k++) begin
                  int j;
                  j = (rr + k) % N;
                  if (g < 0 && a_ready[j] && !a_done[j] && q[j].size() > 0) g = j;
               end
               chk("rnd_grant_expected", 32'(g >= 0), 1);
               if (g >= 0) begin
                  chk("rnd_addr", 32'(wr_addr), 32'(q[g][0]));
                  chk("rnd_data", 32'(wr_data), 32'(colr[g]));
               end
               pending = g;
            end else if (wr_valid) begin
               chk("rnd_hold_addr", 32'(wr_addr), 32'(paddr));
               chk("rnd_hold_data", 32'(wr_data), 32'(pdata));
            end
            if (continue_o != '0) begin
               chk("rnd_accept_seen", 32'(pv && a_wrr), 1);
               if (pending >= 0) begin
                  chk("rnd_cont", 32'(continue_o), 32'(1) << pending);
                  void'(q[pending].pop_front());
                  rr = (pending + 1) % N;
                  rdy[pending] = 1'b0;
                  dly[pending] = $urandom_range(2, 6);
                  pending = -1;
               end else begin
                  chk("rnd_cont_unexpected", 32'(continue_o), 0);
               end
               written++;
               chk("rnd_pc", 32'(pixel_count), 32'(written));
               if (written == FRAME) begin
                  chk("rnd_fd_early", 32'(frame_done), 0);
                  fd_wait = 1'b1;
               end
            end
            pv = wr_valid; paddr = wr_addr; pdata = wr_data;
            for (int s = 0; s < N - 1; s++) begin
               if (!rdy[s] && q[s].size() > 0) begin
                  if (dly[s] == 0) begin
                     rdy[s]  = 1'b1;
                     colr[s] = 4'($urandom_range(0, 15));
                  end else begin
                     dly[s]--;
                  end
               end
            end
            drive_rand();
         end
         chk("rnd_frame_timeout", 32'(fin), 1);
         solver_ready = '1;
         solver_done  = '0;
         wr_ready     = 1'b1;
         for (int k = 0; k < 8; k++) begin
            tick();
            chk("done_no_valid", 32'(wr_valid), 0);
            chk("done_no_cont", 32'(continue_o), 0);
            chk("done_sticky", 32'(frame_done), 1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
